// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from an internal FIFO; frame format (data bits, parity, stop bits) is fixed
// by parameters and bit timing comes from the one-cycle UART_CLK strobe.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        UART_CLK,
  input  logic [DATA_BITS-1:0]        DATA,
  input  logic                        DATA_READY,
  output logic                        TXD,
  output logic                        FULL,
  output logic [$clog2(FIFO_DEPTH):0] LEVEL,
  output logic                        IDLE
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_next;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] head;
  logic [DATA_BITS-1:0] shift;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 parity_bit;
  logic                 push, pop;
  logic                 last_data, last_stop;
  logic                 txd_next;

  assign FULL      = (LEVEL == LW'(FIFO_DEPTH));
  assign push      = DATA_READY && !FULL;
  assign head      = mem[rd_ptr];
  assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= DATA;
  end

  // LEVEL only sees a push on the following cycle, so a word is never popped in the cycle it arrives
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      LEVEL  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      LEVEL <= LEVEL + LW'(1);
      else if (pop && !push) LEVEL <= LEVEL - LW'(1);
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (LEVEL != '0) begin
          pop        = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT:   if (UART_CLK) state_next = S_START;
      S_START:  if (UART_CLK) state_next = S_DATA;
      S_DATA:   if (UART_CLK && last_data) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (UART_CLK) state_next = S_STOP;
      // A queued word chains straight into the next start bit, no idle bit in between
      S_STOP: begin
        if (UART_CLK && last_stop) begin
          if (LEVEL != '0) begin
            pop        = 1'b1;
            state_next = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    txd_next = 1'b1;
    case (state)
      S_START:  txd_next = 1'b0;
      S_DATA:   txd_next = shift[0];
      S_PARITY: txd_next = parity_bit;
      default:  txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      parity_bit <= 1'b0;
      TXD        <= 1'b1;
      IDLE       <= 1'b1;
    end else begin
      state <= state_next;
      TXD   <= txd_next;
      IDLE  <= (state == S_IDLE) && (LEVEL == '0);
      if (pop) begin
        shift      <= head;
        bit_cnt    <= '0;
        stop_cnt   <= 1'b0;
        parity_bit <= (PARITY == 1) ? ~(^head) : ^head;
      end else if (UART_CLK) begin
        if (state == S_DATA) begin
          shift   <= shift >> 1;
          bit_cnt <= bit_cnt + 4'd1;
        end
        if (state == S_STOP) stop_cnt <= ~stop_cnt;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four frame formats driven side by side, every frame decoded by a
// mid-bit sampling receiver and compared with a queue of the words the bench expects on the line.
module tb_uart_tx_fifo;
  localparam int NB [4] = '{8, 7, 9, 5};
  localparam int PR [4] = '{0, 2, 1, 0};
  localparam int NS [4] = '{1, 2, 1, 2};

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       UART_CLK = 1'b0;
  logic [7:0] data0 = '0;
  logic [6:0] data1 = '0;
  logic [8:0] data2 = '0;
  logic [4:0] data3 = '0;
  logic [3:0] dr = '0;
  logic [3:0] txd_b, full_b, idle_b;
  logic [4:0] lvl0;
  logic [2:0] lvl1, lvl2;
  logic [1:0] lvl3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_num = 0;
  int phase = 0;
  bit tick_en = 1'b0;
  int exp_k[$];
  int exp_w[$];
  bit b2b [4] = '{0, 0, 0, 0};
  bit have_prev [4] = '{0, 0, 0, 0};
  int last_start [4] = '{0, 0, 0, 0};

  uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .UART_CLK(UART_CLK), .DATA(data0), .DATA_READY(dr[0]),
    .TXD(txd_b[0]), .FULL(full_b[0]), .LEVEL(lvl0), .IDLE(idle_b[0]));
  uart_tx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .UART_CLK(UART_CLK), .DATA(data1), .DATA_READY(dr[1]),
    .TXD(txd_b[1]), .FULL(full_b[1]), .LEVEL(lvl1), .IDLE(idle_b[1]));
  uart_tx_fifo #(.DATA_BITS(9), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .UART_CLK(UART_CLK), .DATA(data2), .DATA_READY(dr[2]),
    .TXD(txd_b[2]), .FULL(full_b[2]), .LEVEL(lvl2), .IDLE(idle_b[2]));
  uart_tx_fifo #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(2)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .UART_CLK(UART_CLK), .DATA(data3), .DATA_READY(dr[3]),
    .TXD(txd_b[3]), .FULL(full_b[3]), .LEVEL(lvl3), .IDLE(idle_b[3]));

  always #5 CLK = ~CLK;

  // Baud strobe: one CLK-wide pulse every 16 cycles while enabled, changed just after the edge
  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      if (tick_en) begin
        if (phase == 15) begin
          UART_CLK = 1'b1;
          phase    = 0;
          tick_num++;
        end else begin
          UART_CLK = 1'b0;
          phase++;
        end
      end else begin
        UART_CLK = 1'b0;
        phase    = 0;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int level_of(input int k);
    case (k)
      0:       return int'(lvl0);
      1:       return int'(lvl1);
      2:       return int'(lvl2);
      default: return int'(lvl3);
    endcase
  endfunction

  function automatic int pending(input int k);
    int n = 0;
    foreach (exp_k[i]) if (exp_k[i] == k) n++;
    return n;
  endfunction

  task automatic flush_expected(input int k);
    for (int i = exp_k.size() - 1; i >= 0; i--) begin
      if (exp_k[i] == k) begin
        exp_k.delete(i);
        exp_w.delete(i);
      end
    end
  endtask

  // Receiver: sample each bit in its middle and compare against the oldest expected word
  task automatic monitor(input int k);
    int          len, idx, word, rx, t0, p;
    bit          aborted;
    logic        prev;
    logic [15:0] frame;
    len  = 1 + NB[k] + ((PR[k] != 0) ? 1 : 0) + NS[k];
    prev = 1'b1;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        prev = 1'b1;
      end else if (prev === 1'b1 && txd_b[k] === 1'b0) begin
        t0      = cyc;
        aborted = 1'b0;
        frame   = '0;
        for (int b = 0; b < len; b++) begin
          repeat ((b == 0) ? 8 : 16) begin
            @(negedge CLK);
            if (!RST_N) aborted = 1'b1;
          end
          frame[b] = txd_b[k];
        end
        prev = aborted ? 1'b1 : txd_b[k];
        if (!aborted) begin
          idx = -1;
          foreach (exp_k[i]) if (idx < 0 && exp_k[i] == k) idx = i;
          check_output($sformatf("frame_expected_d%0d", k), 32'(idx >= 0), 32'd1);
          if (idx >= 0) begin
            word = exp_w[idx];
            exp_k.delete(idx);
            exp_w.delete(idx);
            rx = 0;
            for (int i = 0; i < NB[k]; i++) if (frame[1 + i]) rx += (1 << i);
            check_output($sformatf("start_bit_d%0d", k), 32'(frame[0]), 32'd0);
            check_output($sformatf("data_d%0d", k), rx, word);
            if (PR[k] != 0) begin
              p = $countones(word) % 2;
              if (PR[k] == 1) p = 1 - p;
              check_output($sformatf("parity_d%0d", k), 32'(frame[1 + NB[k]]), p);
            end
            for (int s = 0; s < NS[k]; s++)
              check_output($sformatf("stop%0d_d%0d", s, k), 32'(frame[len - NS[k] + s]), 32'd1);
            if (b2b[k] && have_prev[k])
              check_output($sformatf("b2b_gap_d%0d", k), t0 - last_start[k], len * 16);
            have_prev[k]  = 1'b1;
            last_start[k] = t0;
          end
        end
      end else begin
        prev = txd_b[k];
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);
  initial monitor(3);

  task automatic apply_stimulus(input int k, input int w, input bit accepted);
    w = w & ((1 << NB[k]) - 1);
    case (k)
      0:       data0 = 8'(w);
      1:       data1 = 7'(w);
      2:       data2 = 9'(w);
      default: data3 = 5'(w);
    endcase
    dr[k] = 1'b1;
    if (accepted) begin
      exp_k.push_back(k);
      exp_w.push_back(w);
    end
    @(negedge CLK);
    dr[k] = 1'b0;
  endtask

  task automatic wait_drain(input int k, input int budget);
    int n = 0;
    while (pending(k) != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check_output($sformatf("drain_done_d%0d", k), pending(k), 0);
    repeat (24) @(negedge CLK);
    check_output($sformatf("idle_after_d%0d", k), 32'(idle_b[k]), 32'd1);
    check_output($sformatf("txd_after_d%0d", k), 32'(txd_b[k]), 32'd1);
    check_output($sformatf("level_after_d%0d", k), level_of(k), 0);
  endtask

  task automatic wait_tick(input int n, input int budget);
    int c = 0;
    while (!(UART_CLK === 1'b1 && tick_num == n) && c < budget) begin
      @(negedge CLK);
      c++;
    end
    check_output($sformatf("tick%0d_reached", n), tick_num, n);
  endtask

  task automatic stop_ticks();
    tick_en = 1'b0;
    @(negedge CLK);
    tick_num = 0;
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #2 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("rst_txd_d%0d", k), 32'(txd_b[k]), 32'd1);
      check_output($sformatf("rst_full_d%0d", k), 32'(full_b[k]), 32'd0);
      check_output($sformatf("rst_level_d%0d", k), level_of(k), 0);
      check_output($sformatf("rst_idle_d%0d", k), 32'(idle_b[k]), 32'd1);
    end
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    tick_en = 1'b1;

    apply_stimulus(0, 'h55, 1'b1);
    wait_drain(0, 600);
    apply_stimulus(1, 'h41, 1'b1);
    wait_drain(1, 600);
    apply_stimulus(2, 'h1FF, 1'b1);
    wait_drain(2, 600);
    apply_stimulus(3, 'h1F, 1'b1);
    wait_drain(3, 600);

    // The first word moves into the shifter one cycle after landing, so depth 4 absorbs five words
    stop_ticks();
    for (int i = 0; i < 6; i++) apply_stimulus(1, $urandom, i < 5);
    check_output("burst_full", 32'(full_b[1]), 32'd1);
    check_output("burst_level", level_of(1), 4);
    check_output("burst_not_idle", 32'(idle_b[1]), 32'd0);
    repeat (5) @(negedge CLK);
    check_output("burst_txd_waiting", 32'(txd_b[1]), 32'd1);
    have_prev[1] = 1'b0;
    b2b[1]       = 1'b1;
    tick_en      = 1'b1;
    wait_drain(1, 5 * 11 * 16 + 300);
    b2b[1] = 1'b0;

    // Frame two's final stop tick is tick 23; push on it while the FIFO holds two words
    stop_ticks();
    for (int i = 0; i < 4; i++) apply_stimulus(1, $urandom, 1'b1);
    check_output("pre_run_level", level_of(1), 3);
    have_prev[1] = 1'b0;
    b2b[1]       = 1'b1;
    tick_en      = 1'b1;
    wait_tick(23, 23 * 16 + 64);
    check_output("simul_level_before", level_of(1), 2);
    apply_stimulus(1, $urandom, 1'b1);
    check_output("simul_level_after", level_of(1), 2);
    wait_drain(1, 5 * 11 * 16 + 300);
    b2b[1] = 1'b0;

    stop_ticks();
    for (int i = 0; i < 4; i++) apply_stimulus(0, $urandom, 1'b1);
    tick_en = 1'b1;
    wait_tick(5, 5 * 16 + 64);
    repeat (8) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_output("midrst_txd", 32'(txd_b[0]), 32'd1);
    check_output("midrst_level", level_of(0), 0);
    check_output("midrst_full", 32'(full_b[0]), 32'd0);
    check_output("midrst_idle", 32'(idle_b[0]), 32'd1);
    flush_expected(0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (400) @(negedge CLK);
    check_output("postrst_txd", 32'(txd_b[0]), 32'd1);
    check_output("postrst_idle", 32'(idle_b[0]), 32'd1);
    check_output("postrst_level", level_of(0), 0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        apply_stimulus(0, $urandom, 1'b1);
        if (i < 4) apply_stimulus(2, $urandom, 1'b1);
        if (i < 2) apply_stimulus(3, $urandom, 1'b1);
        repeat ($urandom_range(0, 40)) @(negedge CLK);
      end
      wait_drain(0, 10 * 10 * 16 + 600);
      wait_drain(2, 4 * 12 * 16 + 600);
      wait_drain(3, 2 * 8 * 16 + 600);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
